// File: rtl/cascade_sequencer_pkg.sv
// Shared types and constants for the INTA cascade sequencer.
// Holds the sequencer state encoding, the CALL opcode and the parameter defaults.
package cascade_pkg;

    localparam int CAS_W_DEF   = 3;
    localparam int TIMEOUT_DEF = 64;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE1,
        ST_WAIT2,
        ST_PULSE2,
        ST_WAIT3,
        ST_PULSE3
    } seq_state_e;

    // Low byte of the 8080 CALL target: A7..A5 from ICW1, then IR index, then 2'b00.
    function automatic logic [7:0] vec_8080(input logic [2:0] adr, input logic [2:0] ir);
        return {adr, ir, 2'b00};
    endfunction

endpackage

// File: rtl/cascade_sequencer_sync2.sv
// Width-parametrised two-flop synchroniser with a selectable reset value.
module sync2 #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cascade_sequencer.sv
// 8259-style INTA cascade sequencer: tracks acknowledge pulses, drives the cascade bus and vector bytes.
// Optional WAIT-state watchdog enabled by defining CASCADE_SEQ_TIMEOUT_EN.
module cascade_sequencer
    import cascade_pkg::*;
#(
    parameter  int CAS_W   = CAS_W_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int N_IR    = 2 ** CAS_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              INTA_N,
    input  logic              SP_EN,
    input  logic              SNGL,
    input  logic              UPM,
    input  logic [N_IR-1:0]   ICW3,
    input  logic [7:0]        ICW2,
    input  logic [2:0]        ICW1_ADR,
    input  logic              IR_VALID,
    input  logic [CAS_W-1:0]  IR_ID,
    input  logic [CAS_W-1:0]  CAS_IN,
    output logic [CAS_W-1:0]  CAS_OUT,
    output logic              CAS_OE,
    output logic [7:0]        DOUT,
    output logic              DOUT_EN,
    output logic              INTA_DONE,
    output logic              SEQ_ERR
);

    if (CAS_W < 1 || CAS_W > 3) begin : g_bad_cas_w
        $error("cascade_sequencer: CAS_W must be in 1..3");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cascade_sequencer: TIMEOUT must be at least 2");
    end

    logic             inta_s;
    logic [CAS_W-1:0] cas_s;

    sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_inta (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (INTA_N),
        .q     (inta_s)
    );

    sync2 #(.W(CAS_W), .RST_VAL({CAS_W{1'b1}})) u_sync_cas (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (CAS_IN),
        .q     (cas_s)
    );

    seq_state_e       state_q, state_d;
    logic             inta_prev_q;
    logic [CAS_W-1:0] cur_ir_q, cur_ir_d;
    logic             cur_vld_q, cur_vld_d;
    logic             upm_q, upm_d;
    logic             claim_q, claim_d;
    logic [CAS_W-1:0] cas_out_q, cas_out_d;
    logic             cas_oe_q, cas_oe_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_en_q, dout_en_d;
    logic             inta_done_q, inta_done_d;

    logic             lead_edge;
    logic             trail_edge;
    logic             final_edge;
    logic             cascaded;
    logic             owner;
    logic [7:0]       vec_8086;
    logic             tmo_hit;

    assign lead_edge  = inta_prev_q & ~inta_s;
    assign trail_edge = ~inta_prev_q & inta_s;

`ifdef CASCADE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             seq_err_q, seq_err_d;
    logic             in_wait;

    always_comb begin
        in_wait   = (state_q == ST_WAIT2) || (state_q == ST_WAIT3);
        tmo_hit   = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));
        tmo_d     = (in_wait && !tmo_hit) ? tmo_q + 1'b1 : '0;
        // A leading edge arriving in the expiry cycle still wins.
        seq_err_d = tmo_hit && !lead_edge;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign SEQ_ERR = seq_err_q;
`else
    assign tmo_hit = 1'b0;
    assign SEQ_ERR = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_ir_d   = cur_ir_q;
        cur_vld_d  = cur_vld_q;
        upm_d      = upm_q;
        claim_d    = claim_q;
        final_edge = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lead_edge) begin
                    state_d   = ST_PULSE1;
                    cur_vld_d = IR_VALID;
                    cur_ir_d  = IR_VALID ? IR_ID : CAS_W'(N_IR - 1);
                    upm_d     = UPM;
                    claim_d   = 1'b0;
                end
            end
            ST_PULSE1: begin
                if (trail_edge) begin
                    state_d = ST_WAIT2;
                    claim_d = !SP_EN && !SNGL && (cas_s == ICW3[CAS_W-1:0]);
                end
            end
            ST_WAIT2: begin
                if (lead_edge) begin
                    state_d = ST_PULSE2;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE2: begin
                if (trail_edge) begin
                    if (upm_q) begin
                        state_d    = ST_IDLE;
                        final_edge = 1'b1;
                    end else begin
                        state_d = ST_WAIT3;
                    end
                end
            end
            ST_WAIT3: begin
                if (lead_edge) begin
                    state_d = ST_PULSE3;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE3: begin
                if (trail_edge) begin
                    state_d    = ST_IDLE;
                    final_edge = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from next-state values so they land with the state change.
        cascaded = SP_EN && !SNGL && cur_vld_d && ICW3[cur_ir_d];
        owner    = SNGL || (SP_EN && !(cur_vld_d && ICW3[cur_ir_d])) || (!SP_EN && claim_d);

        cas_oe_d  = cascaded && (state_d != ST_IDLE);
        cas_out_d = cas_oe_d ? cur_ir_d : '0;

        vec_8086                = ICW2;
        vec_8086[CAS_W-1:0]     = cur_ir_d;

        dout_d    = 8'h00;
        dout_en_d = 1'b0;
        case (state_d)
            ST_PULSE1: begin
                if (!upm_d && (SP_EN || SNGL)) begin
                    dout_en_d = 1'b1;
                    dout_d    = CALL_OPCODE;
                end
            end
            ST_PULSE2: begin
                if (owner) begin
                    dout_en_d = 1'b1;
                    dout_d    = upm_d ? vec_8086 : vec_8080(ICW1_ADR, 3'(cur_ir_d));
                end
            end
            ST_PULSE3: begin
                if (owner) begin
                    dout_en_d = 1'b1;
                    dout_d    = ICW2;
                end
            end
            default: ;
        endcase

        inta_done_d = final_edge && owner;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            inta_prev_q <= 1'b1;
            cur_ir_q    <= '0;
            cur_vld_q   <= 1'b0;
            upm_q       <= 1'b0;
            claim_q     <= 1'b0;
            cas_out_q   <= '0;
            cas_oe_q    <= 1'b0;
            dout_q      <= 8'h00;
            dout_en_q   <= 1'b0;
            inta_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= inta_s;
            cur_ir_q    <= cur_ir_d;
            cur_vld_q   <= cur_vld_d;
            upm_q       <= upm_d;
            claim_q     <= claim_d;
            cas_out_q   <= cas_out_d;
            cas_oe_q    <= cas_oe_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            inta_done_q <= inta_done_d;
        end
    end

    assign CAS_OUT   = cas_out_q;
    assign CAS_OE    = cas_oe_q;
    assign DOUT      = dout_q;
    assign DOUT_EN   = dout_en_q;
    assign INTA_DONE = inta_done_q;

endmodule

// File: doc/cascade_sequencer.md
CASCADE_SEQUENCER -- requirements
Module: cascade_sequencer

Interface
REQ-001 SHALL have parameter CAS_W, default 3, cascade address width; legal range 1..3.
REQ-002 SHALL have parameter N_IR, default 2**CAS_W, number of IR inputs or slaves; fixed, not overridable.
REQ-003 SHALL have parameter TIMEOUT, default 64, watchdog limit in CLK cycles; used only with the macro in REQ-030.
REQ-004 SHALL have ports CLK in 1, system clock; RST_N in 1, reset.
REQ-005 SHALL use one clock, CLK; RST_N SHALL be an asynchronous, active-low reset.
REQ-006 SHALL have ports INTA_N in 1, CPU acknowledge pin, active-low; SP_EN in 1, 1=master 0=slave; SNGL in 1, single mode; UPM in 1, 1=8086 (2 pulses) 0=8080 (3 pulses).
REQ-007 SHALL have ports ICW3 in N_IR, master: slave-present mask, slave: ID in [CAS_W-1:0]; ICW2 in 8, vector base or CALL high byte; ICW1_ADR in 3, 8080 A7..A5.
REQ-008 SHALL have ports IR_VALID in 1, resolver has a winner; IR_ID in CAS_W, winning IR index; CAS_IN in CAS_W, cascade bus sampled.
REQ-009 SHALL have ports CAS_OUT out CAS_W; CAS_OE out 1; DOUT out 8; DOUT_EN out 1; INTA_DONE out 1, one-cycle pulse; SEQ_ERR out 1, one-cycle pulse.

Function
REQ-010 SHALL pass INTA_N and CAS_IN through 2-flop synchronisers; leading edge = synced 1->0, trailing edge = synced 0->1; outputs react 3 CLK after the pin edge.
REQ-011 SHALL implement FSM states IDLE, PULSE1, WAIT2, PULSE2, WAIT3, PULSE3.
REQ-012 IDLE->PULSE1 on leading edge; PULSE1->WAIT2 on trailing edge; WAIT2->PULSE2 on leading edge; PULSE2->IDLE (UPM=1) or ->WAIT3 (UPM=0) on trailing edge; WAIT3->PULSE3 on leading edge; PULSE3->IDLE on trailing edge.
REQ-013 SHALL latch IR_ID into cur_ir and IR_VALID into cur_vld at the PULSE1 leading edge; if IR_VALID=0, cur_ir SHALL be N_IR-1 (spurious) and no CAS drive SHALL occur.
REQ-014 Master, SNGL=0, cur_vld=1, ICW3[cur_ir]=1: CAS_OUT=cur_ir and CAS_OE=1 from the PULSE1 leading edge until the final trailing edge; otherwise CAS_OUT=0 and CAS_OE=0.
REQ-015 Slave, SNGL=0: SHALL set claim=1 at the PULSE1 trailing edge when synced CAS_IN equals ICW3[CAS_W-1:0], else claim=0.
REQ-016 Data owner: SNGL=1, or master with ICW3[cur_ir]=0 or cur_vld=0, or slave with claim=1.
REQ-017 UPM=1: DOUT={ICW2[7:CAS_W], cur_ir} with DOUT_EN=1 during PULSE2 when owner; nothing in PULSE1.
REQ-018 UPM=0: PULSE1 DOUT=8'hCD driven by master or SNGL only; PULSE2 DOUT={ICW1_ADR, cur_ir zero-extended to 3 bits, 2'b00}; PULSE3 DOUT=ICW2; both only when owner.
REQ-019 DOUT SHALL be 8'h00 whenever DOUT_EN=0.
REQ-020 INTA_DONE SHALL pulse for one CLK on the final trailing edge when owner.
REQ-021 A leading edge in any WAIT state with UPM changed mid-sequence SHALL follow the UPM value latched at PULSE1.
REQ-022 Slave with SNGL=0 and claim=0 SHALL not assert DOUT_EN or INTA_DONE, but SHALL still track pulses back to IDLE.

Reset
REQ-023 RST_N low SHALL asynchronously force state IDLE, CAS_OUT=0, CAS_OE=0, DOUT=0, DOUT_EN=0, INTA_DONE=0, SEQ_ERR=0, claim=0, cur_ir=0, cur_vld=0, synchronisers=1.
REQ-024 Reset mid-sequence SHALL abort the sequence; after release the FSM SHALL wait in IDLE for a fresh leading edge.

Configuration
REQ-030 With CASCADE_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT2 and WAIT3; on reaching TIMEOUT it SHALL return to IDLE, drop CAS_OE and DOUT_EN, and pulse SEQ_ERR for one CLK.
REQ-031 Without CASCADE_SEQ_TIMEOUT_EN, no counter SHALL exist and SEQ_ERR SHALL be tied 0.

Structure
REQ-040 Package cascade_pkg SHALL hold the FSM state enum, the CALL opcode constant 8'hCD and the default CAS_W/TIMEOUT.
REQ-041 Sub-module sync2 (2-flop synchroniser, width-parametrised) SHALL be instantiated for INTA_N and CAS_IN.

Verification
REQ-050 Master UPM=1, ICW2=8'h40, ICW3=8'h00, IR_ID=5 -> CAS_OE=0; second pulse DOUT=8'h45, DOUT_EN=1; INTA_DONE once.
REQ-051 Master UPM=0, ICW3=8'h04, IR_ID=2 -> CAS_OUT=2, CAS_OE=1 across 3 pulses; DOUT=8'hCD on pulse1; DOUT_EN=0 on pulses 2-3.
REQ-052 Slave ID=2, UPM=0, ICW1_ADR=3'b101, ICW2=8'h12, CAS_IN=2 -> pulse2 DOUT=8'hA8, pulse3 DOUT=8'h12; with CAS_IN=3 -> DOUT_EN never 1.
REQ-053 IR_VALID=0, UPM=1, ICW2=8'h40 -> DOUT=8'h47 (spurious IR7).
REQ-054 RST_N low during PULSE2 -> all outputs 0 immediately; next full sequence completes normally.
REQ-055 With CASCADE_SEQ_TIMEOUT_EN and TIMEOUT=64, stall in WAIT2 for 64 CLK -> SEQ_ERR one-cycle pulse, CAS_OE=0, state IDLE.
